half_rate_packer: RTL

- Sits directly downstream of the full-rate (clk1x) producer. Consumes one DW-bit word per accepted clk1x cycle and packs RATIO consecutive words into one wide output word.
- The packed output is presented with a valid/ready handshake, so the consumer can run at 1/RATIO rate without a derived clock.
- Also generates a free-running clock-enable strobe (div_en) and phase flag (div_phase). These replace flop-generated divided clocks. Nothing downstream may use div_phase as a clock.

---
 rtl/half_rate_packer_if.sv | 30 +++
 rtl/half_rate_packer.sv | 117 +++++++++++
 2 files changed

// File: rtl/half_rate_packer_if.sv
// Handshake bundle between the full-rate producer, the packer and the wide-word consumer.
// Optional flush/out_lanes signals exist only when HALF_RATE_PACKER_FLUSH_EN is defined.
interface half_rate_packer_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RATIO = 2
);
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DW*RATIO-1:0]   out_data;
  logic                  out_ready;

`ifdef HALF_RATE_PACKER_FLUSH_EN
  localparam int unsigned LW = $clog2(RATIO + 1);
  logic                  flush;
  logic [LW-1:0]         out_lanes;

  // master = environment (producer + consumer), slave = packer
  modport master (output in_valid, in_data, out_ready, flush,
                  input  in_ready, out_valid, out_data, out_lanes);
  modport slave  (input  in_valid, in_data, out_ready, flush,
                  output in_ready, out_valid, out_data, out_lanes);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/half_rate_packer.sv
// Packs RATIO full-rate words into one wide valid/ready word and emits a div_en/div_phase strobe.
// Optional partial-word flush enabled by defining HALF_RATE_PACKER_FLUSH_EN.
module half_rate_packer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RATIO = 2,
  parameter int unsigned DIV   = 2
) (
  input  logic              clk1x,
  input  logic              rst,
  half_rate_packer_if.slave bus,
  output logic              div_en,
  output logic              div_phase
);
  localparam int unsigned CW  = $clog2(RATIO);
  localparam int unsigned DCW = $clog2(DIV);
  localparam int unsigned BW  = DW * (RATIO - 1);
  localparam int unsigned OW  = DW * RATIO;

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  buf_q, buf_d;
  logic           out_valid_q, out_valid_d;
  logic [OW-1:0]  out_data_q, out_data_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           div_en_q, div_en_d;
  logic           div_phase_q, div_phase_d;

  logic last_c, in_ready_c, xfer_c, load_c, flush_c, div_wrap_c;

`ifdef HALF_RATE_PACKER_FLUSH_EN
  localparam int unsigned LW = $clog2(RATIO + 1);
  logic [LW-1:0] out_lanes_q, out_lanes_d;

  // Flush only fires when there is a partial word and somewhere to put it
  assign flush_c       = bus.flush && (cnt_q != '0) && (!out_valid_q || bus.out_ready);
  assign bus.out_lanes = out_lanes_q;
`else
  assign flush_c = 1'b0;
`endif

  assign last_c     = (cnt_q == CW'(RATIO - 1));
  assign in_ready_c = !rst && !(last_c && out_valid_q && !bus.out_ready) && !flush_c;
  assign xfer_c     = bus.in_valid && in_ready_c;
  assign load_c     = xfer_c && last_c;
  assign div_wrap_c = (div_cnt_q == DCW'(DIV - 1));

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign div_en        = div_en_q;
  assign div_phase     = div_phase_q;

  // Pack buffer is cleared on every emit so flushed words carry zero upper lanes
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
`ifdef HALF_RATE_PACKER_FLUSH_EN
    out_lanes_d = out_lanes_q;
`endif
    if (load_c) begin
      cnt_d       = '0;
      buf_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = {bus.in_data, buf_q};
`ifdef HALF_RATE_PACKER_FLUSH_EN
      out_lanes_d = LW'(RATIO);
`endif
    end else if (flush_c) begin
      cnt_d       = '0;
      buf_d       = '0;
      out_valid_d = 1'b1;
      out_data_d  = {DW'(0), buf_q};
`ifdef HALF_RATE_PACKER_FLUSH_EN
      out_lanes_d = LW'(cnt_q);
`endif
    end else if (xfer_c) begin
      cnt_d = cnt_q + CW'(1);
      for (int unsigned i = 0; i < RATIO - 1; i++) begin
        if (cnt_q == CW'(i)) buf_d[i*DW +: DW] = bus.in_data;
      end
    end
  end

  // Free-running divider, independent of the data path
  always_comb begin
    div_cnt_d   = div_wrap_c ? '0 : div_cnt_q + DCW'(1);
    div_en_d    = div_wrap_c;
    div_phase_d = div_phase_q ^ div_wrap_c;
  end

  always_ff @(posedge clk1x) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      div_cnt_q   <= '0;
      div_en_q    <= 1'b0;
      div_phase_q <= 1'b0;
`ifdef HALF_RATE_PACKER_FLUSH_EN
      out_lanes_q <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      div_cnt_q   <= div_cnt_d;
      div_en_q    <= div_en_d;
      div_phase_q <= div_phase_d;
`ifdef HALF_RATE_PACKER_FLUSH_EN
      out_lanes_q <= out_lanes_d;
`endif
    end
  end
endmodule
